// File: rtl/keypad_pkg.sv
// Shared key codes, FSM state encoding and helpers for the keypad entry path.
package keypad_pkg;

    localparam logic [3:0] KEY_BKSP  = 4'hE;
    localparam logic [3:0] KEY_ENTER = 4'hF;
    localparam logic [3:0] KEY_CLEAR = 4'hD;

    typedef enum logic {
        ENTRY,
        OFFER
    } entry_state_t;

    function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = KEY_BKSP;
            4'hD: code = 4'h0;
            4'hE: code = KEY_ENTER;
            default: code = KEY_CLEAR;
        endcase
        return code;
    endfunction

    function automatic logic [15:0] bcd_to_bin(input logic [15:0] bcd);
        return 16'(bcd[15:12]) * 16'd1000 + 16'(bcd[11:8]) * 16'd100
             + 16'(bcd[7:4]) * 16'd10 + 16'(bcd[3:0]);
    endfunction

endpackage

// File: rtl/keypad_scan.sv
// 4x4 keypad column scanner with row synchronizer, full-scan debounce and
// single-key press event detection.
module keypad_scan #(
    parameter int unsigned SCAN_DIV       = 100000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic       clk_100mhz,
    input  logic       reset,
    output logic [3:0] col_drive,
    input  logic [3:0] row_sense,
    output logic       key_valid,
    output logic [3:0] key_code
);
    import keypad_pkg::*;

    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam int unsigned RUN_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(DEBOUNCE_SCANS);

    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       col_idx;
    logic [3:0]       row_meta;
    logic [3:0]       row_sync;
    logic [15:0]      snap_work;
    logic [15:0]      prev_snap;
    logic [15:0]      deb_map;
    logic [RUN_W-1:0] run_len;

    logic             slot_end;
    logic             scan_done;
    logic [15:0]      snap_next;
    logic [RUN_W-1:0] run_next;
    logic [3:0]       hit_pos;

    assign col_drive = ~(4'b0001 << col_idx);
    assign slot_end  = (div_cnt == DIV_LAST);
    assign scan_done = slot_end && (col_idx == 2'd3);

    // snap_next already holds the current column's rows, so at the end of the
    // column-3 slot it is the completed snapshot.
    always_comb begin
        snap_next = snap_work;
        for (int unsigned r = 0; r < 4; r++) begin
            snap_next[{r[1:0], col_idx}] = ~row_sync[r];
        end

        if (snap_next != prev_snap) begin
            run_next = RUN_W'(1);
        end else if (run_len != RUN_MAX) begin
            run_next = run_len + 1'b1;
        end else begin
            run_next = run_len;
        end

        hit_pos = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (snap_next[i]) begin
                hit_pos = 4'(i);
            end
        end
    end

    always_ff @(posedge clk_100mhz or posedge reset) begin
        if (reset) begin
            div_cnt   <= '0;
            col_idx   <= '0;
            row_meta  <= '1;
            row_sync  <= '1;
            snap_work <= '0;
            prev_snap <= '0;
            deb_map   <= '0;
            run_len   <= '0;
            key_valid <= 1'b0;
            key_code  <= '0;
        end else begin
            key_valid <= 1'b0;
            row_meta  <= row_sense;
            row_sync  <= row_meta;

            if (slot_end) begin
                div_cnt   <= '0;
                col_idx   <= col_idx + 2'd1;
                snap_work <= snap_next;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            if (scan_done) begin
                prev_snap <= snap_next;
                run_len   <= run_next;
                if (run_next == RUN_MAX) begin
                    deb_map <= snap_next;
                    if ((deb_map == '0) && $onehot(snap_next)) begin
                        key_valid <= 1'b1;
                        key_code  <= key_lookup(hit_pos[3:2], hit_pos[1:0]);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/keypad_entry.sv
// Keypad digit entry: BCD digit buffer with edit keys, and valid/ready offer
// of the entered value to the core.
module keypad_entry #(
    parameter int unsigned SCAN_DIV       = 100000,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter int unsigned MAX_DIGITS     = 4
) (
    input  logic        clk_100mhz,
    input  logic        reset,
    output logic [3:0]  col_drive,
    input  logic [3:0]  row_sense,
    output logic [15:0] entry_value,
    output logic        entry_valid,
    input  logic        entry_ready,
    output logic [15:0] echo_value,
    output logic [2:0]  digit_count,
    output logic        key_err
);
    import keypad_pkg::*;

    logic         key_valid;
    logic [3:0]   key_code;
    entry_state_t state;
    entry_state_t state_next;
    logic [15:0]  bcd;
    logic [15:0]  bcd_next;
    logic [2:0]   count_next;
    logic [15:0]  value_next;
    logic         err_next;

    keypad_scan #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_scan (
        .clk_100mhz (clk_100mhz),
        .reset      (reset),
        .col_drive  (col_drive),
        .row_sense  (row_sense),
        .key_valid  (key_valid),
        .key_code   (key_code)
    );

    assign echo_value  = bcd_to_bin(bcd);
    assign entry_valid = (state == OFFER);

    always_ff @(posedge clk_100mhz or posedge reset) begin
        if (reset) begin
            state       <= ENTRY;
            bcd         <= '0;
            digit_count <= '0;
            entry_value <= '0;
            key_err     <= 1'b0;
        end else begin
            state       <= state_next;
            bcd         <= bcd_next;
            digit_count <= count_next;
            entry_value <= value_next;
            key_err     <= err_next;
        end
    end

    always_comb begin
        state_next = state;
        bcd_next   = bcd;
        count_next = digit_count;
        value_next = entry_value;
        err_next   = 1'b0;

        case (state)
            ENTRY: begin
                if (key_valid) begin
                    if (key_code <= 4'd9) begin
                        if (digit_count < 3'(MAX_DIGITS)) begin
                            bcd_next   = {bcd[11:0], key_code};
                            count_next = digit_count + 3'd1;
                        end else begin
                            err_next = 1'b1;
                        end
                    end else if (key_code == KEY_BKSP) begin
                        if (digit_count != '0) begin
                            bcd_next   = {4'h0, bcd[15:4]};
                            count_next = digit_count - 3'd1;
                        end
                    end else if (key_code == KEY_CLEAR) begin
                        bcd_next   = '0;
                        count_next = '0;
                    end else if (key_code == KEY_ENTER) begin
                        if (digit_count != '0) begin
                            value_next = echo_value;
                            bcd_next   = '0;
                            count_next = '0;
                            state_next = OFFER;
                        end else begin
                            err_next = 1'b1;
                        end
                    end
                end
            end
            OFFER: begin
                if (key_valid) begin
                    err_next = 1'b1;
                end
                if (entry_ready) begin
                    state_next = ENTRY;
                end
            end
            default: state_next = ENTRY;
        endcase
    end

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry: a behavioural key matrix drives row_sense
// from col_drive, and each step compares outputs against hand-derived values.
`timescale 1ns/1ps
module tb_keypad_entry;

    localparam int K1 = 0, K2 = 1, K3 = 2, K4 = 4, K5 = 5, K6 = 6;
    localparam int K7 = 8, K8 = 9, K9 = 10, KSTAR = 12, KHASH = 14, KD = 15;

    logic        clk_100mhz = 1'b0;
    logic        reset;
    logic [3:0]  col_drive;
    logic [3:0]  row_sense;
    logic [15:0] entry_value;
    logic        entry_valid;
    logic        entry_ready;
    logic [15:0] echo_value;
    logic [2:0]  digit_count;
    logic        key_err;
    logic [15:0] keys;

    int errors = 0;
    int checks = 0;
    int err_pulses = 0;
    int valid_cycles = 0;
    int e0;
    int v0;
    logic [3:0] walk [5];

    keypad_entry #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (2),
        .MAX_DIGITS     (4)
    ) dut (
        .clk_100mhz  (clk_100mhz),
        .reset       (reset),
        .col_drive   (col_drive),
        .row_sense   (row_sense),
        .entry_value (entry_value),
        .entry_valid (entry_valid),
        .entry_ready (entry_ready),
        .echo_value  (echo_value),
        .digit_count (digit_count),
        .key_err     (key_err)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    always_comb begin
        for (int r = 0; r < 4; r++) begin
            row_sense[r] = ~|(keys[r*4 +: 4] & ~col_drive);
        end
    end

    always @(negedge clk_100mhz) begin
        if (key_err) err_pulses++;
        if (entry_valid) valid_cycles++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic press(input int pos);
        keys = '0;
        keys[pos] = 1'b1;
        repeat (80) @(negedge clk_100mhz);
        keys = '0;
        repeat (80) @(negedge clk_100mhz);
    endtask

    initial begin
        walk[0] = 4'b1110; walk[1] = 4'b1101; walk[2] = 4'b1011;
        walk[3] = 4'b0111; walk[4] = 4'b1110;
        reset = 1'b1;
        keys = '0;
        entry_ready = 1'b0;
        repeat (3) @(negedge clk_100mhz);
        reset = 1'b0;
        repeat (6) @(negedge clk_100mhz);

        // asynchronous reset in the middle of a clock phase
        @(posedge clk_100mhz);
        #2 reset = 1'b1;
        #1;
        check("rst_col", 32'(col_drive), 32'b1110);
        check("rst_value", 32'(entry_value), 0);
        check("rst_valid", 32'(entry_valid), 0);
        check("rst_echo", 32'(echo_value), 0);
        check("rst_count", 32'(digit_count), 0);
        check("rst_err", 32'(key_err), 0);
        @(negedge clk_100mhz);
        reset = 1'b0;
        for (int k = 0; k <= 16; k++) begin
            if (k % 4 == 0) check("col_walk", 32'(col_drive), 32'(walk[k / 4]));
            if (k == 3) check("col_slot_end", 32'(col_drive), 32'b1110);
            @(negedge clk_100mhz);
        end

        // entry 1234 then enter with consumer not ready
        press(K1);
        check("echo_1", 32'(echo_value), 1);
        press(K2);
        check("echo_12", 32'(echo_value), 12);
        press(K3);
        check("echo_123", 32'(echo_value), 123);
        press(K4);
        check("echo_1234", 32'(echo_value), 1234);
        check("count_4", 32'(digit_count), 4);
        press(KHASH);
        check("enter_echo", 32'(echo_value), 0);
        check("enter_count", 32'(digit_count), 0);
        check("enter_valid", 32'(entry_valid), 1);
        check("enter_value", 32'(entry_value), 1234);
        v0 = valid_cycles;
        repeat (50) @(negedge clk_100mhz);
        check("hold_cycles", 32'(valid_cycles - v0), 50);
        check("hold_value", 32'(entry_value), 1234);
        entry_ready = 1'b1;
        @(negedge clk_100mhz);
        entry_ready = 1'b0;
        check("hs_valid", 32'(entry_valid), 0);
        check("hs_value_kept", 32'(entry_value), 1234);

        // overflow on the fifth digit
        e0 = err_pulses;
        press(K9); press(K8); press(K7); press(K6);
        press(K5);
        check("ovf_echo", 32'(echo_value), 9876);
        check("ovf_count", 32'(digit_count), 4);
        check("ovf_err", 32'(err_pulses - e0), 1);
        press(KD);

        // editing keys
        press(K4); press(K2); press(KSTAR);
        check("bksp_echo", 32'(echo_value), 4);
        check("bksp_count", 32'(digit_count), 1);
        press(KD);
        check("clr_echo", 32'(echo_value), 0);
        check("clr_count", 32'(digit_count), 0);
        e0 = err_pulses;
        press(KSTAR);
        check("bksp0_count", 32'(digit_count), 0);
        check("bksp0_err", 32'(err_pulses - e0), 0);

        // bouncing contact: alternate every full scan, then hold
        for (int i = 0; i < 6; i++) begin
            keys = '0;
            keys[K1] = (i % 2 == 0);
            repeat (16) @(negedge clk_100mhz);
        end
        press(K1);
        check("bounce_echo", 32'(echo_value), 1);
        check("bounce_count", 32'(digit_count), 1);

        // two keys together produce nothing
        keys = '0;
        keys[K5] = 1'b1;
        keys[K6] = 1'b1;
        repeat (80) @(negedge clk_100mhz);
        keys = '0;
        repeat (80) @(negedge clk_100mhz);
        check("multi_count", 32'(digit_count), 1);
        press(K7);
        check("after_multi_echo", 32'(echo_value), 17);
        check("after_multi_count", 32'(digit_count), 2);
        press(KD);

        // enter with no digits
        e0 = err_pulses;
        v0 = valid_cycles;
        press(KHASH);
        check("empty_err", 32'(err_pulses - e0), 1);
        check("empty_valid", 32'(valid_cycles - v0), 0);

        // keys are rejected while offering
        press(K5); press(KHASH);
        check("offer_valid", 32'(entry_valid), 1);
        e0 = err_pulses;
        press(K3);
        check("offer_err", 32'(err_pulses - e0), 1);
        check("offer_value", 32'(entry_value), 5);
        check("offer_echo", 32'(echo_value), 0);
        check("offer_still_valid", 32'(entry_valid), 1);
        entry_ready = 1'b1;
        @(negedge clk_100mhz);
        check("offer_hs", 32'(entry_valid), 0);

        // ready already high: exactly one valid cycle
        press(K8);
        v0 = valid_cycles;
        press(KHASH);
        check("early_ready_cycles", 32'(valid_cycles - v0), 1);
        check("early_ready_value", 32'(entry_value), 8);
        entry_ready = 1'b0;

        // reset while offering drops valid at once
        press(K2); press(KHASH);
        check("pre_rst_valid", 32'(entry_valid), 1);
        @(posedge clk_100mhz);
        #3 reset = 1'b1;
        #1;
        check("offer_rst_valid", 32'(entry_valid), 0);
        check("offer_rst_value", 32'(entry_value), 0);
        @(negedge clk_100mhz);
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
